nibble_bus_master: RTL and testbench
====================================

NIBBLE_BUS_MASTER -- requirements
Module: nibble_bus_master

Interface
REQ-001 clk_in  in  1  single clock; all logic on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 cmd_valid  in  1  command request; accepted on a cycle where cmd_valid=1 and cmd_ready=1.
REQ-004 cmd_ready  out  1  high only in IDLE.
REQ-005 cmd_code  in  4  bus command: 1 GET PARAMS, 2 SEND PARAMS, 3 TX IQ, 5 RESET ON, 6 RESET OFF, 8 GET INFO.
REQ-006 param_data  in  164  GET PARAMS payload, 41 nibbles, bits [163:160] sent first.
REQ-007 tx_iq  in  64  TX IQ payload, Q in [63:32] then I in [31:0], 16 nibbles, MSB first.
REQ-008 rd_data  out  76  read result, first nibble received in [75:72]; unused low nibbles zero.
REQ-009 rd_valid  out  1  one-cycle pulse when rd_data is complete.
REQ-010 cmd_error  out  1  one-cycle pulse when an unsupported cmd_code is accepted.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 DATA_SYNC  out  1  frame start strobe toward the transceiver FPGA interface.
REQ-013 DATA_BUS  inout  4  nibble bus; driven only while bus_oe=1, otherwise high-Z.

Function
REQ-014 States: IDLE, SYNC, WRITE, TURN, READ, DONE.
REQ-015 On accept in IDLE, the block latches cmd_code, param_data and tx_iq into internal registers and moves to SYNC; later input changes have no effect on the frame.
REQ-016 SYNC (one cycle): DATA_SYNC=1, bus_oe=1, DATA_BUS=cmd_code.
REQ-017 Payload lengths: code 1 = 41 nibbles written; code 3 = 16 written; code 2 = 19 read; code 8 = 6 read; codes 5 and 6 = 0.
REQ-018 SYNC to WRITE for codes 1 and 3, to TURN for codes 2 and 8, to DONE for codes 5 and 6.
REQ-019 WRITE: one nibble per cycle, MSB first, with bus_oe=1 and DATA_SYNC=0. A 6-bit nibble counter runs from 0 to N-1; after the last nibble the block goes to DONE.
REQ-020 TURN (one cycle): bus_oe=0 and DATA_SYNC=0, giving the slave its register-to-output cycle.
REQ-021 READ: bus_oe=0; DATA_BUS is sampled on each rising edge for N consecutive cycles, shifted into rd_data from [75:72] downward; after nibble N-1 the block goes to DONE.
REQ-022 Read latency: the first nibble is sampled at the end of cycle 2, counting SYNC as cycle 0; the last nibble is sampled at the end of cycle N+1.
REQ-023 DONE (one cycle): rd_valid=1 for codes 2 and 8 only; the block then returns to IDLE.
REQ-024 Back-to-back commands: minimum spacing is one IDLE cycle between DONE and the next SYNC.
REQ-025 An unsupported code is accepted and gives SYNC then DONE (cmd byte still emitted) with cmd_error=1 in DONE, no payload and no rd_valid.
REQ-026 rd_data holds its value until the next read command's first sample; it is cleared to zero at that command's SYNC.
REQ-027 DATA_SYNC is never high outside SYNC, and bus_oe is never high in TURN or READ (no bus contention).
REQ-028 cmd_valid while busy is ignored and not queued.

Reset
REQ-029 reset asserted in any state forces IDLE immediately: DATA_SYNC=0, bus_oe=0 (DATA_BUS high-Z), cmd_ready=1, busy=0, rd_valid=0, cmd_error=0, rd_data=0, counter=0.
REQ-030 A frame aborted by reset is not resumed; the first command after reset release starts with SYNC.

Verification
REQ-031 Code 3 with tx_iq=64'h1234_5678_9ABC_DEF0 -> SYNC nibble 3, then nibbles 1,2,...,F,0 on 16 consecutive cycles; busy for 18 cycles.
REQ-032 Code 2 with a bus model driving nibble values 0..18 mod 16 on cycles 2..20 -> rd_valid in cycle 21, rd_data[75:0] = 0123456789ABCDEF012 (hex).
REQ-033 Code 8 with the slave returning 0,3,0,5,0,0 -> rd_data[75:52]=24'h030500, low bits 0.
REQ-034 Code 1 with all-ones param_data -> 41 nibbles of F, then DONE; monitor confirms DATA_SYNC is high for exactly one cycle.
REQ-035 Reset asserted at nibble 7 of a code 1 frame -> DATA_BUS high-Z and cmd_ready=1 in the same cycle; a new code 5 command gives SYNC nibble 5 only.
REQ-036 Code 4 -> SYNC nibble 4, cmd_error pulse in cycle 1, no rd_valid; cmd_valid held high throughout a frame is accepted only in IDLE.

Source files
------------

// File: rtl/nibble_bus_master_if.sv
// nibble_bus_master_if
// Command and status signals that pass between a command source and the
// nibble bus master.
//   cmd_valid/cmd_ready  command handshake (accept when both are high)
//   cmd_code             4-bit bus command
//   param_data           41-nibble GET PARAMS payload, MSB nibble first
//   tx_iq                16-nibble TX IQ payload, Q in [63:32], I in [31:0]
//   rd_data              read result, first received nibble in [75:72]
//   rd_valid             one-cycle pulse when rd_data is complete
//   cmd_error            one-cycle pulse for an unsupported command
//   busy                 master is outside IDLE
//   DATA_SYNC            frame start strobe toward the transceiver
//   bus_oe               master is driving DATA_BUS this cycle
interface nibble_bus_master_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_code;
    logic [163:0] param_data;
    logic [63:0]  tx_iq;
    logic [75:0]  rd_data;
    logic         rd_valid;
    logic         cmd_error;
    logic         busy;
    logic         DATA_SYNC;
    logic         bus_oe;

    modport master (
        input  cmd_valid, cmd_code, param_data, tx_iq,
        output cmd_ready, rd_data, rd_valid, cmd_error, busy, DATA_SYNC, bus_oe
    );

    modport slave (
        output cmd_valid, cmd_code, param_data, tx_iq,
        input  cmd_ready, rd_data, rd_valid, cmd_error, busy, DATA_SYNC, bus_oe
    );
endinterface

// File: rtl/nibble_bus_master.sv
// nibble_bus_master
// Frames commands onto a 4-bit bidirectional bus: one SYNC cycle carrying the
// command nibble, then either a burst of written nibbles, or a turnaround
// cycle followed by a burst of read nibbles, then a single DONE cycle.
// Ports:
//   clk_in    single clock, rising edge
//   reset     asynchronous, active-high; returns the master to IDLE at once
//   bus       command/status interface (master modport)
//   DATA_BUS  bidirectional nibble bus, high-Z whenever bus_oe is low
module nibble_bus_master (
    input  logic                clk_in,
    input  logic                reset,
    nibble_bus_master_if.master bus,
    inout  wire  [3:0]          DATA_BUS
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SYNC  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_TURN  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [3:0] C_GET_PARAMS  = 4'd1;
    localparam logic [3:0] C_SEND_PARAMS = 4'd2;
    localparam logic [3:0] C_TX_IQ       = 4'd3;
    localparam logic [3:0] C_RESET_ON    = 4'd5;
    localparam logic [3:0] C_RESET_OFF   = 4'd6;
    localparam logic [3:0] C_GET_INFO    = 4'd8;

    function automatic logic [5:0] payload_len(input logic [3:0] code);
        case (code)
            C_GET_PARAMS:  payload_len = 6'd41;
            C_TX_IQ:       payload_len = 6'd16;
            C_SEND_PARAMS: payload_len = 6'd19;
            C_GET_INFO:    payload_len = 6'd6;
            default:       payload_len = 6'd0;
        endcase
    endfunction

    function automatic logic is_write(input logic [3:0] code);
        is_write = (code == C_GET_PARAMS) || (code == C_TX_IQ);
    endfunction

    function automatic logic is_read(input logic [3:0] code);
        is_read = (code == C_SEND_PARAMS) || (code == C_GET_INFO);
    endfunction

    function automatic logic is_known(input logic [3:0] code);
        is_known = is_write(code) || is_read(code) ||
                   (code == C_RESET_ON) || (code == C_RESET_OFF);
    endfunction

    logic [2:0]   state;
    logic [3:0]   cmd_r;
    logic [163:0] wr_shift;
    logic [5:0]   cnt;
    logic [75:0]  rd_data_r;
    logic [5:0]   last_idx;
    logic [6:0]   rd_pos;
    logic         bus_oe;
    logic [3:0]   out_nib;

    assign last_idx = payload_len(cmd_r) - 6'd1;
    // Read nibble k lands at [75-4k -: 4], i.e. bit offset 72-4k.
    assign rd_pos   = 7'd72 - {cnt[4:0], 2'b00};

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 6'd0;
            cmd_r     <= 4'd0;
            rd_data_r <= 76'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_r <= bus.cmd_code;
                        cnt   <= 6'd0;
                        state <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    cnt <= 6'd0;
                    if (is_write(cmd_r)) begin
                        state <= S_WRITE;
                    end else if (is_read(cmd_r)) begin
                        rd_data_r <= 76'd0;
                        state     <= S_TURN;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_WRITE: begin
                    if (cnt == last_idx) begin
                        cnt   <= 6'd0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_TURN: begin
                    state <= S_READ;
                end
                S_READ: begin
                    rd_data_r[rd_pos +: 4] <= DATA_BUS;
                    if (cnt == last_idx) begin
                        cnt   <= 6'd0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Payload shifter: loaded on accept so later input changes cannot
    // disturb the frame; the top nibble is always the next one to send.
    always_ff @(posedge clk_in) begin
        if (state == S_IDLE && bus.cmd_valid) begin
            wr_shift <= (bus.cmd_code == C_TX_IQ) ? {bus.tx_iq, 100'd0} : bus.param_data;
        end else if (state == S_WRITE) begin
            wr_shift <= {wr_shift[159:0], 4'd0};
        end
    end

    assign bus_oe   = (state == S_SYNC) || (state == S_WRITE);
    assign out_nib  = (state == S_SYNC) ? cmd_r : wr_shift[163:160];
    assign DATA_BUS = bus_oe ? out_nib : 4'bzzzz;

    assign bus.bus_oe    = bus_oe;
    assign bus.DATA_SYNC = (state == S_SYNC);
    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.rd_valid  = (state == S_DONE) && is_read(cmd_r);
    assign bus.cmd_error = (state == S_DONE) && !is_known(cmd_r);
    assign bus.rd_data   = rd_data_r;

endmodule

// File: tb/tb_nibble_bus_master.sv
module tb_nibble_bus_master;

    logic       clk_in;
    logic       reset;
    wire  [3:0] data_bus;
    logic       slave_oe;
    logic [3:0] slave_val;
    logic [3:0] slave_nib [19];
    logic [75:0] rd_model;
    int         total;
    int         bad;

    nibble_bus_master_if b ();

    nibble_bus_master dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .bus      (b),
        .DATA_BUS (data_bus)
    );

    assign data_bus = slave_oe ? slave_val : 4'bzzzz;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a frame is the command nibble followed by the write payload;
    // reads return the slave nibbles packed from the top of rd_data.
    task automatic run_cmd(input logic [3:0] code, input logic [163:0] param,
                           input logic [63:0] iq, input bit hold_valid);
        int nw = 0;
        int nr = 0;
        int last;
        int busy_cnt = 0;
        int sync_cnt = 0;
        bit rd_cmd = 0;
        bit err_cmd = 0;
        logic [3:0] exp_nib [$];
        logic [163:0] tmp;
        logic [75:0] exp_rd = '0;

        case (code)
            4'd1: nw = 41;
            4'd3: nw = 16;
            4'd2: nr = 19;
            4'd8: nr = 6;
            4'd5, 4'd6: ;
            default: err_cmd = 1;
        endcase
        rd_cmd = (nr != 0);
        exp_nib.push_back(code);
        for (int i = 0; i < nw; i++) begin
            if (code == 4'd1) tmp = param >> (4 * (40 - i));
            else              tmp = {100'd0, iq} >> (4 * (15 - i));
            exp_nib.push_back(tmp[3:0]);
        end
        for (int i = 0; i < nr; i++) exp_rd = (exp_rd << 4) | {72'd0, slave_nib[i]};
        if (rd_cmd) exp_rd = exp_rd << (4 * (19 - nr));
        last = rd_cmd ? nr + 2 : nw + 1;

        check("idle_ready", {75'd0, b.cmd_ready}, 76'd1);
        b.cmd_valid  = 1'b1;
        b.cmd_code   = code;
        b.param_data = param;
        b.tx_iq      = iq;

        for (int k = 0; k <= last + 1; k++) begin
            @(posedge clk_in);
            #1;
            if (!hold_valid || k == last) b.cmd_valid = 1'b0;
            b.cmd_code   = 4'($urandom);
            b.param_data = 164'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            b.tx_iq      = {$urandom, $urandom};
            if (rd_cmd && k >= 2 && k <= nr + 1) begin
                slave_oe  = 1'b1;
                slave_val = slave_nib[k - 2];
            end else begin
                slave_oe  = 1'b0;
            end
            #1;
            if (b.busy) busy_cnt++;
            if (b.DATA_SYNC) sync_cnt++;
            if (k <= last) begin
                check($sformatf("busy_c%0d", k), {75'd0, b.busy}, 76'd1);
                check($sformatf("ready_c%0d", k), {75'd0, b.cmd_ready}, 76'd0);
                check($sformatf("sync_c%0d", k), {75'd0, b.DATA_SYNC}, {75'd0, k == 0});
                check($sformatf("oe_c%0d", k), {75'd0, b.bus_oe}, {75'd0, k < exp_nib.size()});
                if (k < exp_nib.size())
                    check($sformatf("nib_c%0d", k), {72'd0, data_bus}, {72'd0, exp_nib[k]});
                check($sformatf("rdv_c%0d", k), {75'd0, b.rd_valid}, {75'd0, k == last && rd_cmd});
                check($sformatf("err_c%0d", k), {75'd0, b.cmd_error}, {75'd0, k == last && err_cmd});
                if (k == last) begin
                    if (rd_cmd) rd_model = exp_rd;
                    check("rd_data_done", b.rd_data, rd_model);
                end
            end else begin
                check("after_ready", {75'd0, b.cmd_ready}, 76'd1);
                check("after_busy", {75'd0, b.busy}, 76'd0);
                check("after_oe", {75'd0, b.bus_oe}, 76'd0);
                check("after_rdv", {75'd0, b.rd_valid}, 76'd0);
            end
        end
        check("busy_cycles", 76'(busy_cnt), 76'(last + 1));
        check("sync_cycles", 76'(sync_cnt), 76'd1);
    endtask

    initial begin
        int tbl [10] = '{1, 2, 3, 5, 6, 8, 0, 4, 7, 15};
        logic [3:0] code;
        total       = 0;
        bad         = 0;
        rd_model    = '0;
        slave_oe    = 1'b0;
        slave_val   = 4'd0;
        b.cmd_valid = 1'b0;
        b.cmd_code  = 4'd0;
        b.param_data = '0;
        b.tx_iq     = '0;
        for (int i = 0; i < 19; i++) slave_nib[i] = 4'd0;
        reset = 1'b1;

        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_ready", {75'd0, b.cmd_ready}, 76'd1);
        check("rst_busy", {75'd0, b.busy}, 76'd0);
        check("rst_sync", {75'd0, b.DATA_SYNC}, 76'd0);
        check("rst_oe", {75'd0, b.bus_oe}, 76'd0);
        check("rst_rd_data", b.rd_data, 76'd0);
        reset = 1'b0;
        @(posedge clk_in);
        #2;

        // TX IQ directed frame
        run_cmd(4'd3, '0, 64'h1234_5678_9ABC_DEF0, 1'b0);

        // SEND PARAMS: slave returns 0..18 mod 16
        for (int i = 0; i < 19; i++) slave_nib[i] = 4'(i % 16);
        run_cmd(4'd2, '0, '0, 1'b0);
        check("req032_rd", b.rd_data, 76'h0123456789ABCDEF012);

        // GET INFO: slave returns 0,3,0,5,0,0
        slave_nib[0] = 4'd0; slave_nib[1] = 4'd3; slave_nib[2] = 4'd0;
        slave_nib[3] = 4'd5; slave_nib[4] = 4'd0; slave_nib[5] = 4'd0;
        run_cmd(4'd8, '0, '0, 1'b0);
        check("req033_rd", b.rd_data, {24'h030500, 52'd0});

        // GET PARAMS all ones
        run_cmd(4'd1, {164{1'b1}}, '0, 1'b0);

        // Unsupported code with cmd_valid held through the frame
        run_cmd(4'd4, '0, '0, 1'b1);
        check("rd_hold_after_err", b.rd_data, {24'h030500, 52'd0});

        // Reset in the middle of a GET PARAMS frame, at nibble 7
        b.cmd_valid  = 1'b1;
        b.cmd_code   = 4'd1;
        b.param_data = {164{1'b1}};
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk_in);
            #1;
            b.cmd_valid = 1'b0;
        end
        check("mid_oe_before", {75'd0, b.bus_oe}, 76'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_oe", {75'd0, b.bus_oe}, 76'd0);
        check("mid_rst_ready", {75'd0, b.cmd_ready}, 76'd1);
        check("mid_rst_busy", {75'd0, b.busy}, 76'd0);
        check("mid_rst_sync", {75'd0, b.DATA_SYNC}, 76'd0);
        check("mid_rst_rd_data", b.rd_data, 76'd0);
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        rd_model = '0;
        @(posedge clk_in);
        #2;
        check("post_rst_ready", {75'd0, b.cmd_ready}, 76'd1);
        run_cmd(4'd5, '0, '0, 1'b0);

        // Random commands against the reference model
        for (int n = 0; n < 24; n++) begin
            code = 4'(tbl[$urandom_range(9)]);
            for (int i = 0; i < 19; i++) slave_nib[i] = 4'($urandom);
            run_cmd(code,
                    164'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}),
                    {$urandom, $urandom}, 1'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
